// File: rtl/afu_pkg.sv
// Shared AFU constants: default queue geometry, count width, and the MMIO user-register address.
// No ports; imported by the data queue, its storage, and its bus interface.
package afu_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    localparam logic [15:0] MMIO_USER_REG_ADDR = 16'h0020;

    // Pointer width for a given depth; never narrower than one bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mmio_data_queue_if.sv
// MMIO data-queue bus: push/pop strobes, popped data, occupancy and sticky error flags.
// master: MMIO side driving strobes; slave: the queue.
interface mmio_data_queue_if #(
    parameter int unsigned DATA_W = afu_pkg::DATA_W,
    parameter int unsigned DEPTH  = afu_pkg::DEPTH
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic              clr_err;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, full, empty, count, overflow, underflow
    );

endinterface

// File: rtl/mmio_queue_ram.sv
// Queue storage: one write port, one synchronous read port with read enable, no reset.
// Ports: clk, i_we/i_waddr/i_wdata (write), i_re/i_raddr (read), o_rdata (registered read data).
module mmio_queue_ram import afu_pkg::*; #(
    parameter int unsigned DATA_W = afu_pkg::DATA_W,
    parameter int unsigned DEPTH  = afu_pkg::DEPTH,
    parameter int unsigned PTR_W  = ptr_w(afu_pkg::DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [PTR_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [PTR_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;

    // Read returns the pre-write contents when both ports hit the same address.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_q <= r_mem[i_raddr];
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/mmio_data_queue.sv
// MMIO data queue: circular-buffer FIFO behind an MMIO user register with sticky error flags.
// Ports: clk, rst_n (async active-low), bus (slave modport: strobes in; data, occupancy, flags out).
module mmio_data_queue import afu_pkg::*; #(
    parameter int unsigned DATA_W = afu_pkg::DATA_W,
    parameter int unsigned DEPTH  = afu_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    mmio_data_queue_if.slave  bus
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_rd_valid;
    logic              r_rd_loaded;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_push;
    logic              w_pop;
    logic              w_ovf;
    logic              w_unf;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [DATA_W-1:0] w_ram_q;

    // A full queue still accepts a push when a pop frees a slot at the same edge.
    assign w_pop  = bus.rd_en && !r_empty;
    assign w_push = bus.wr_en && (!r_full || bus.rd_en);
    assign w_ovf  = bus.wr_en && r_full && !bus.rd_en;
    assign w_unf  = bus.rd_en && r_empty;

    // Next occupancy.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, occupancy, registered full/empty and pop strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_rd_valid  <= 1'b0;
            r_rd_loaded <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty    <= (w_count_nxt == '0);
            r_rd_valid <= w_pop;
            if (w_pop) r_rd_loaded <= 1'b1;
        end
    end

    // Sticky error flags; a new error wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf)            r_overflow  <= 1'b1;
            else if (bus.clr_err) r_overflow  <= 1'b0;
            if (w_unf)            r_underflow <= 1'b1;
            else if (bus.clr_err) r_underflow <= 1'b0;
        end
    end

    mmio_queue_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.wr_data),
        .i_re    (w_pop),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_q)
    );

    // The storage read register has no reset, so rd_data reads as zero until the first pop after reset.
    assign bus.rd_data   = r_rd_loaded ? w_ram_q : '0;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.full      = r_full;
    assign bus.empty     = r_empty;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

endmodule

// File: tb/tb_mmio_data_queue.sv
// Directed bench for mmio_data_queue with a scoreboard of expected popped data.
module tb_mmio_data_queue;

    logic clk;
    logic rst_n;

    mmio_data_queue_if #(.DATA_W(64), .DEPTH(8)) bus ();

    mmio_data_queue #(.DATA_W(64), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; returns 1 time unit after the edge.
    task automatic cyc(input logic we, input logic [63:0] wd, input logic re, input logic ce);
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_en   = re;
        bus.clr_err = ce;
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
    endtask

    task automatic pop_exp(input logic [63:0] exp);
        sb.push_back(exp);
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
    endtask

    // Monitor: every rd_valid pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rd_valid: got data %0h expected no pop", bus.rd_data);
            end else begin
                chk("rd_data", bus.rd_data, sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_empty", 64'(bus.empty), 64'd1);
        chk("rst_full", 64'(bus.full), 64'd0);
        chk("rst_rd_data", bus.rd_data, 64'd0);
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("rst_ovf", 64'(bus.overflow), 64'd0);
        chk("rst_unf", 64'(bus.underflow), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        cyc(1'b0, 64'h0, 1'b0, 1'b0);

        // Basic A, B, C ordering
        cyc(1'b1, 64'hA, 1'b0, 1'b0);
        cyc(1'b1, 64'hB, 1'b0, 1'b0);
        cyc(1'b1, 64'hC, 1'b0, 1'b0);
        chk("abc_count", 64'(bus.count), 64'd3);
        pop_exp(64'hA);
        pop_exp(64'hB);
        pop_exp(64'hC);
        cyc(1'b0, 64'h0, 1'b0, 1'b0);
        chk("abc_empty", 64'(bus.empty), 64'd1);
        chk("abc_count0", 64'(bus.count), 64'd0);

        // Underflow and clear
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        chk("unf_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("unf_flag", 64'(bus.underflow), 64'd1);
        chk("unf_rd_data_hold", bus.rd_data, 64'hC);
        cyc(1'b0, 64'h0, 1'b0, 1'b1);
        chk("unf_cleared", 64'(bus.underflow), 64'd0);

        // Overflow: 9 pushes into 8 slots
        for (int i = 0; i < 9; i++) cyc(1'b1, 64'h100 + 64'(i), 1'b0, 1'b0);
        chk("ovf_full", 64'(bus.full), 64'd1);
        chk("ovf_count", 64'(bus.count), 64'd8);
        chk("ovf_flag", 64'(bus.overflow), 64'd1);
        for (int i = 0; i < 8; i++) pop_exp(64'h100 + 64'(i));
        cyc(1'b0, 64'h0, 1'b0, 1'b1);
        chk("ovf_drained", 64'(bus.empty), 64'd1);
        chk("ovf_cleared", 64'(bus.overflow), 64'd0);

        // Push and pop on a full queue
        for (int i = 0; i < 8; i++) cyc(1'b1, 64'h200 + 64'(i), 1'b0, 1'b0);
        sb.push_back(64'h200);
        cyc(1'b1, 64'hFF, 1'b1, 1'b0);
        chk("fullpp_count", 64'(bus.count), 64'd8);
        chk("fullpp_full", 64'(bus.full), 64'd1);
        chk("fullpp_ovf", 64'(bus.overflow), 64'd0);
        for (int i = 1; i < 8; i++) pop_exp(64'h200 + 64'(i));
        pop_exp(64'hFF);
        chk("fullpp_empty", 64'(bus.empty), 64'd1);

        // Interleaved 20 entries; occupancy stays at 1
        cyc(1'b1, 64'h300, 1'b0, 1'b0);
        for (int i = 1; i < 20; i++) begin
            sb.push_back(64'h300 + 64'(i - 1));
            cyc(1'b1, 64'h300 + 64'(i), 1'b1, 1'b0);
            chk("ilv_count_le2", 64'(bus.count <= 2), 64'd1);
        end
        pop_exp(64'h300 + 64'd19);
        chk("ilv_empty", 64'(bus.empty), 64'd1);

        // Push and pop on an empty queue: push only, underflow set
        cyc(1'b1, 64'h400, 1'b1, 1'b0);
        chk("epp_count", 64'(bus.count), 64'd1);
        chk("epp_unf", 64'(bus.underflow), 64'd1);
        chk("epp_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("epp_rd_data_hold", bus.rd_data, 64'h313);
        pop_exp(64'h400);
        cyc(1'b0, 64'h0, 1'b0, 1'b1);
        chk("epp_cleared", 64'(bus.underflow), 64'd0);

        // New error wins over same-cycle clear
        cyc(1'b0, 64'h0, 1'b1, 1'b1);
        chk("clr_vs_err", 64'(bus.underflow), 64'd1);
        cyc(1'b0, 64'h0, 1'b0, 1'b1);
        chk("clr_after", 64'(bus.underflow), 64'd0);

        // Asynchronous reset with 5 entries queued
        for (int i = 0; i < 5; i++) cyc(1'b1, 64'h500 + 64'(i), 1'b0, 1'b0);
        chk("pre_rst_count", 64'(bus.count), 64'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_empty", 64'(bus.empty), 64'd1);
        chk("arst_count", 64'(bus.count), 64'd0);
        chk("arst_rd_data", bus.rd_data, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        chk("arst_pop_unf", 64'(bus.underflow), 64'd1);
        chk("arst_pop_valid", 64'(bus.rd_valid), 64'd0);

        cyc(1'b0, 64'h0, 1'b0, 1'b0);
        cyc(1'b0, 64'h0, 1'b0, 1'b0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
